// File: rtl/clock_pkg.sv
// Shared types and constants for the alarm clock datapath and controller.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SET    = 2'd1,
    ST_RING   = 2'd2,
    ST_SNOOZE = 2'd3
  } alarm_state_t;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_HOUR = 2'd1;
  localparam logic [1:0] SEL_MIN  = 2'd2;
  localparam logic [1:0] SEL_SEC  = 2'd3;

  localparam int unsigned TIME_W = 32;

  // Nibble lanes counted from the LSB: {s0,s1,A,m0,m1,A,h0,h1}
  localparam int unsigned LANE_H1    = 0;
  localparam int unsigned LANE_H0    = 1;
  localparam int unsigned LANE_SEP_HM = 2;
  localparam int unsigned LANE_M1    = 3;
  localparam int unsigned LANE_M0    = 4;
  localparam int unsigned LANE_SEP_MS = 5;
  localparam int unsigned LANE_S1    = 6;
  localparam int unsigned LANE_S0    = 7;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [TIME_W-1:0] digit_mask();
    logic [TIME_W-1:0] m;
    m = '1;
    m[LANE_SEP_HM*4 +: 4] = 4'h0;
    m[LANE_SEP_MS*4 +: 4] = 4'h0;
    return m;
  endfunction

  // Counter strobe bit for the field under edit: bit0 sec, bit1 min, bit2 hour
  function automatic logic [2:0] sel_strobe(input logic [1:0] s);
    case (s)
      SEL_HOUR: return 3'b100;
      SEL_MIN:  return 3'b010;
      SEL_SEC:  return 3'b001;
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Rising-edge detect plus hold/auto-repeat timer for one debounced key level.
module key_repeat #(
  parameter int unsigned HOLD_CYC   = 50_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic en,
  input  logic key,
  input  logic block,
  output logic fire_c
);
  import clock_pkg::*;

  localparam int unsigned CW = $clog2(max_u(max_u(HOLD_CYC, REPEAT_CYC), 2) + 1);

  logic          key_q;
  logic          rep_q, rep_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds the cycle index (relative to the last pulse) of the upcoming cycle
  always_comb begin
    fire_c = 1'b0;
    cnt_d  = cnt_q;
    rep_d  = rep_q;
    if (!en || !key || block) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (!key_q) begin
      fire_c = 1'b1;
      cnt_d  = CW'(2);
      rep_d  = 1'b0;
    end else if ((!rep_q && cnt_q >= CW'(HOLD_CYC)) || (rep_q && cnt_q >= CW'(REPEAT_CYC))) begin
      fire_c = 1'b1;
      cnt_d  = CW'(1);
      rep_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      key_q <= 1'b0;
      rep_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      key_q <= key;
      rep_q <= rep_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: time-field editing with auto-repeat, arm, ring, snooze.
module alarm_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned HOLD_CYC   = 50_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000,
  parameter int unsigned RING_S     = 60,
  parameter int unsigned SNOOZE_S   = 300,
  parameter int unsigned SNOOZE_MAX = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              tick_1s,
  input  logic              key_set,
  input  logic              key_up,
  input  logic              key_down,
  input  logic              key_arm,
  input  logic              key_snooze,
  input  logic [TIME_W-1:0] cur_time,
  input  logic [TIME_W-1:0] alarm_time,
  output logic [2:0]        cnt_inc,
  output logic [2:0]        cnt_dec,
  output logic [1:0]        sel,
  output logic              armed,
  output logic              buzzer
);

  localparam int unsigned SW = $clog2(max_u(max_u(RING_S, SNOOZE_S), 1) + 1);
  localparam int unsigned NW = $clog2(max_u(SNOOZE_MAX, 1) + 1);

  alarm_state_t  state_q, state_d;
  logic [1:0]    sel_d;
  logic          armed_d, buzzer_d;
  logic [2:0]    cnt_inc_d, cnt_dec_d;
  logic [SW-1:0] sec_q, sec_d, sec_inc;
  logic [NW-1:0] snz_q, snz_d;
  logic          trig_q, trig_raw;
  logic          time_eq, up_fire, dn_fire, in_set;

  assign in_set  = (state_q == ST_SET);
  assign time_eq = ((cur_time & digit_mask()) == (alarm_time & digit_mask()));
  assign sec_inc = sec_q + SW'(1);

  key_repeat #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_rep_up (
    .Clk(Clk), .Reset(Reset), .en(in_set), .key(key_up), .block(key_down), .fire_c(up_fire)
  );

  key_repeat #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_rep_dn (
    .Clk(Clk), .Reset(Reset), .en(in_set), .key(key_down), .block(key_up), .fire_c(dn_fire)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    sel_d     = sel;
    armed_d   = armed;
    sec_d     = sec_q;
    snz_d     = snz_q;
    trig_raw  = armed && time_eq && (state_q == ST_IDLE);
    buzzer_d  = 1'b0;
    cnt_inc_d = 3'b000;
    cnt_dec_d = 3'b000;

    case (state_q)
      ST_IDLE: begin
        if (trig_raw && !trig_q) begin
          state_d = ST_RING;
          sec_d   = '0;
          snz_d   = '0;
        end else if (key_set) begin
          state_d = ST_SET;
          sel_d   = SEL_HOUR;
        end
      end
      ST_SET: begin
        if (key_set) begin
          if (sel == SEL_SEC) begin
            state_d = ST_IDLE;
            sel_d   = SEL_NONE;
          end else begin
            sel_d = sel + 2'd1;
          end
        end
      end
      ST_RING: begin
        if (key_snooze && (snz_q < NW'(SNOOZE_MAX))) begin
          state_d = ST_SNOOZE;
          snz_d   = snz_q + NW'(1);
          sec_d   = '0;
        end else if (tick_1s) begin
          if (sec_inc >= SW'(RING_S)) begin
            state_d = ST_IDLE;
            sec_d   = '0;
          end else begin
            sec_d = sec_inc;
          end
        end
      end
      ST_SNOOZE: begin
        if (tick_1s) begin
          if (sec_inc >= SW'(SNOOZE_S)) begin
            state_d = ST_RING;
            sec_d   = '0;
          end else begin
            sec_d = sec_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Arm key overrides everything else, including a same-cycle snooze
    if (key_arm) begin
      if (state_q == ST_RING || state_q == ST_SNOOZE) begin
        state_d = ST_IDLE;
        armed_d = 1'b0;
        sec_d   = '0;
      end else begin
        armed_d = ~armed;
      end
    end

    buzzer_d = (state_d == ST_RING);
    if (state_d == ST_SET) begin
      if (up_fire) cnt_inc_d = sel_strobe(sel);
      if (dn_fire) cnt_dec_d = sel_strobe(sel);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      sel     <= SEL_NONE;
      armed   <= 1'b0;
      buzzer  <= 1'b0;
      cnt_inc <= 3'b000;
      cnt_dec <= 3'b000;
      sec_q   <= '0;
      snz_q   <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel     <= sel_d;
      armed   <= armed_d;
      buzzer  <= buzzer_d;
      cnt_inc <= cnt_inc_d;
      cnt_dec <= cnt_dec_d;
      sec_q   <= sec_d;
      snz_q   <= snz_d;
      trig_q  <= trig_raw;
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl with shortened timing parameters.
module tb_alarm_ctrl;
  import clock_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        tick_1s, key_set, key_up, key_down, key_arm, key_snooze;
  logic [31:0] cur_time, alarm_time;
  logic [2:0]  cnt_inc, cnt_dec;
  logic [1:0]  sel;
  logic        armed, buzzer;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] T_ZERO    = 32'h00A00A00;
  localparam logic [31:0] T_ALARM   = 32'h00A30A07;
  localparam logic [31:0] T_ALARM_X = 32'h00530507;
  localparam logic [31:0] T_NEXT    = 32'h01A30A07;

  alarm_ctrl #(
    .HOLD_CYC(8), .REPEAT_CYC(4), .RING_S(4), .SNOOZE_S(2), .SNOOZE_MAX(3)
  ) dut (
    .Clk(Clk), .Reset(Reset), .tick_1s(tick_1s), .key_set(key_set),
    .key_up(key_up), .key_down(key_down), .key_arm(key_arm), .key_snooze(key_snooze),
    .cur_time(cur_time), .alarm_time(alarm_time),
    .cnt_inc(cnt_inc), .cnt_dec(cnt_dec), .sel(sel), .armed(armed), .buzzer(buzzer)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press_set();    key_set = 1'b1;    step(); key_set = 1'b0;    endtask
  task automatic press_arm();    key_arm = 1'b1;    step(); key_arm = 1'b0;    endtask
  task automatic press_snooze(); key_snooze = 1'b1; step(); key_snooze = 1'b0; endtask
  task automatic do_tick();      tick_1s = 1'b1;    step(); tick_1s = 1'b0;    endtask

  logic [21:0] seen, exp_mask;
  int          npulse, bad;

  initial begin
    Reset = 1'b1;
    {tick_1s, key_set, key_up, key_down, key_arm, key_snooze} = '0;
    cur_time   = T_ZERO;
    alarm_time = T_ALARM;
    step(); step();
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_buzzer", 32'(buzzer), 32'd0);
    chk("rst_cnt", {26'd0, cnt_inc, cnt_dec}, 32'd0);
    Reset = 1'b0;
    step();

    // Edit mode entry and hour-field decrement
    press_set();
    chk("set_sel1", 32'(sel), 32'd1);
    key_down = 1'b1; step();
    chk("dec_hour", 32'(cnt_dec), 32'b100);
    key_down = 1'b0; step();
    press_set();
    chk("set_sel2", 32'(sel), 32'd2);

    // key_up held three cycles gives exactly one minute pulse
    npulse = 0; bad = 0;
    for (int i = 0; i < 3; i++) begin
      key_up = 1'b1; step();
      if (cnt_inc != 3'b000) npulse++;
      if (cnt_inc != 3'b000 && cnt_inc != 3'b010) bad++;
    end
    key_up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (cnt_inc != 3'b000) npulse++;
    end
    chk("up3_count", 32'(npulse), 32'd1);
    chk("up3_value", 32'(bad), 32'd0);

    // Both keys held: no pulses on either output past the hold time
    npulse = 0;
    key_up = 1'b1; key_down = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (cnt_inc != 3'b000 || cnt_dec != 3'b000) npulse++;
    end
    key_up = 1'b0; key_down = 1'b0; step();
    chk("both_none", 32'(npulse), 32'd0);

    // Auto-repeat timing on key_down held 20 cycles
    seen = '0; bad = 0;
    exp_mask = '0;
    exp_mask[1] = 1'b1; exp_mask[8] = 1'b1; exp_mask[12] = 1'b1;
    exp_mask[16] = 1'b1; exp_mask[20] = 1'b1;
    key_down = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      step();
      if (i == 20) key_down = 1'b0;
      seen[i] = (cnt_dec != 3'b000);
      if (cnt_dec != 3'b000 && cnt_dec != 3'b010) bad++;
      if (cnt_inc != 3'b000) bad++;
    end
    chk("repeat_mask", 32'(seen), 32'(exp_mask));
    chk("repeat_value", 32'(bad), 32'd0);

    // Seconds field, then leave edit mode
    press_set();
    chk("set_sel3", 32'(sel), 32'd3);
    key_up = 1'b1; step();
    chk("inc_sec", 32'(cnt_inc), 32'b001);
    key_up = 1'b0; step();
    press_set();
    chk("set_exit", 32'(sel), 32'd0);
    key_up = 1'b1; step();
    chk("idle_no_inc", 32'(cnt_inc), 32'd0);
    key_up = 1'b0; step();

    // Arm, match with differing separator nibbles, ring for RING_S ticks
    press_arm();
    chk("armed_on", 32'(armed), 32'd1);
    cur_time = T_ALARM_X; step();
    chk("ring_start", 32'(buzzer), 32'd1);
    cur_time = T_NEXT;
    do_tick(); do_tick(); do_tick();
    chk("ring_3ticks", 32'(buzzer), 32'd1);
    do_tick();
    chk("ring_stop", 32'(buzzer), 32'd0);
    chk("ring_idle", 32'(dut.state_q), 32'(ST_IDLE));
    chk("ring_armed", 32'(armed), 32'd1);

    // Retrigger, then three snoozes and an ignored fourth
    cur_time = T_ALARM; step();
    chk("ring2_start", 32'(buzzer), 32'd1);
    cur_time = T_NEXT;
    for (int n = 0; n < 3; n++) begin
      press_snooze();
      chk("snooze_quiet", 32'(buzzer), 32'd0);
      do_tick();
      chk("snooze_1tick", 32'(buzzer), 32'd0);
      do_tick();
      chk("snooze_resume", 32'(buzzer), 32'd1);
    end
    press_snooze();
    chk("snooze4_ignored", 32'(buzzer), 32'd1);

    // Arm and snooze together: arm wins, no retrigger on held equal time
    cur_time = T_ALARM;
    key_arm = 1'b1; key_snooze = 1'b1; step();
    key_arm = 1'b0; key_snooze = 1'b0;
    chk("arm_win_buzz", 32'(buzzer), 32'd0);
    chk("arm_win_armed", 32'(armed), 32'd0);
    chk("arm_win_idle", 32'(dut.state_q), 32'(ST_IDLE));
    for (int i = 0; i < 5; i++) step();
    chk("no_retrigger", 32'(buzzer), 32'd0);

    // Asynchronous reset in the middle of a ring
    press_arm();
    step();
    chk("ring3_start", 32'(buzzer), 32'd1);
    #2 Reset = 1'b1;
    #1;
    chk("async_buzzer", 32'(buzzer), 32'd0);
    chk("async_armed", 32'(armed), 32'd0);
    chk("async_idle", 32'(dut.state_q), 32'(ST_IDLE));
    step();
    Reset = 1'b0;
    step();
    chk("post_rst_buzzer", 32'(buzzer), 32'd0);
    chk("post_rst_out", {27'd0, sel, cnt_inc != 3'b000, cnt_dec != 3'b000}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
